// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock front-panel controller.
//   state_e    : controller states
//   MODE_*     : encoding of the mode bus driven to the time counter
//   HR_MAX/MIN_MAX : wrap points for alarm hour/minute editing
//   wrap_inc() : 6-bit increment that wraps to zero past a maximum
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_TIME,
    ST_SET_ALARM,
    ST_RING,
    ST_SNOOZE
  } state_e;

  localparam logic [1:0] MODE_RUN       = 2'b00;
  localparam logic [1:0] MODE_SET_TIME  = 2'b01;
  localparam logic [1:0] MODE_SET_ALARM = 2'b10;
  localparam logic [1:0] MODE_RING      = 2'b11;

  localparam logic [5:0] HR_MAX  = 6'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
    return (v >= max_v) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/alarm_mode_ctrl_sec_countdown.sv
// Second countdown shared by ring and snooze timing.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; saturates at zero
//   count      : current count
//   zero       : count == 0
module sec_countdown #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Front-panel controller for the 1 Hz time-of-day counter: mode cycling,
// set-time increment requests, alarm storage/matching, ring and snooze.
//   clk, rst_n        : system clock, async active-low reset
//   tick_1hz          : one-cycle second strobe (time counter update edge)
//   btn_mode/hr/min/snz : one-cycle debounced presses
//   cur_h/m/s         : current time from the time counter
//   mode              : 00 RUN/SNOOZE, 01 SET_TIME, 10 SET_ALARM, 11 RING
//   time_set          : high in SET_TIME
//   inc_hr/inc_min    : pending increment requests to the time counter
//   alm_h/alm_m/alm_en: stored alarm time and arm flag
//   buzzer/snoozing   : high in RING / SNOOZE
// Handshake: inc_hr/inc_min act as valid, tick_1hz as the consumer's ready;
// a request is retired on the cycle after it was seen together with a tick.
// All outputs come straight from flops.
module alarm_mode_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int ALM_H_RST  = 7,
  parameter int ALM_M_RST  = 0,
  parameter int CNT_W      = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_hr,
  input  logic       btn_min,
  input  logic       btn_snz,
  input  logic [5:0] cur_h,
  input  logic [5:0] cur_m,
  input  logic [5:0] cur_s,
  output logic [1:0] mode,
  output logic       time_set,
  output logic       inc_hr,
  output logic       inc_min,
  output logic [5:0] alm_h,
  output logic [5:0] alm_m,
  output logic       alm_en,
  output logic       buzzer,
  output logic       snoozing
);

  state_e state_d, state_q;

  logic [1:0] mode_d, mode_q;
  logic       time_set_d, time_set_q;
  logic       buzzer_d, buzzer_q;
  logic       snoozing_d, snoozing_q;
  logic       inc_hr_d, inc_hr_q;
  logic       inc_min_d, inc_min_q;
  logic [5:0] alm_h_d, alm_h_q;
  logic [5:0] alm_m_d, alm_m_q;
  logic       alm_en_d, alm_en_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_count;
  logic             cnt_zero;
  logic             cnt_expire;
  logic             alarm_match;

  sec_countdown #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  // Alarm fires only on the tick that lands on second 0 of the alarm minute.
  assign alarm_match = tick_1hz && alm_en_q && (cur_h == alm_h_q) &&
                       (cur_m == alm_m_q) && (cur_s == 6'd0);

  // The count reaches zero on this tick (a stuck zero also counts as expired).
  assign cnt_expire = tick_1hz && (cnt_zero || (cnt_count == CNT_W'(1)));

  assign cnt_dec = tick_1hz && ((state_q == ST_RING) || (state_q == ST_SNOOZE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; btn_mode always takes precedence.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      ST_RUN: begin
        if (btn_mode) begin
          state_d = ST_SET_TIME;
        end else if (alarm_match) begin
          state_d      = ST_RING;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(RING_SEC);
        end
      end
      ST_SET_TIME: begin
        if (btn_mode) state_d = ST_SET_ALARM;
      end
      ST_SET_ALARM: begin
        if (btn_mode) state_d = ST_RUN;
      end
      ST_RING: begin
        if (btn_mode) begin
          state_d = ST_RUN;
        end else if (btn_snz) begin
          state_d      = ST_SNOOZE;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(SNOOZE_SEC);
        end else if (cnt_expire) begin
          state_d = ST_RUN;
        end
      end
      ST_SNOOZE: begin
        if (btn_mode) begin
          state_d = ST_RUN;
        end else if (cnt_expire) begin
          state_d      = ST_RING;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(RING_SEC);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output decode from the next state so the flopped outputs track state_q.
  always_comb begin
    mode_d     = MODE_RUN;
    time_set_d = 1'b0;
    buzzer_d   = 1'b0;
    snoozing_d = 1'b0;
    case (state_d)
      ST_SET_TIME:  begin mode_d = MODE_SET_TIME;  time_set_d = 1'b1; end
      ST_SET_ALARM: begin mode_d = MODE_SET_ALARM; end
      ST_RING:      begin mode_d = MODE_RING;      buzzer_d   = 1'b1; end
      ST_SNOOZE:    begin mode_d = MODE_RUN;       snoozing_d = 1'b1; end
      default:      begin mode_d = MODE_RUN; end
    endcase
  end

  // Increment requests and alarm storage. A pending request ignores further
  // presses and is retired by the next tick, even after leaving SET_TIME.
  always_comb begin
    inc_hr_d  = inc_hr_q  ? !tick_1hz : (btn_hr  && (state_q == ST_SET_TIME));
    inc_min_d = inc_min_q ? !tick_1hz : (btn_min && (state_q == ST_SET_TIME));
    alm_h_d   = alm_h_q;
    alm_m_d   = alm_m_q;
    alm_en_d  = alm_en_q;
    if (state_q == ST_SET_ALARM) begin
      if (btn_hr)  alm_h_d  = wrap_inc(alm_h_q, HR_MAX);
      if (btn_min) alm_m_d  = wrap_inc(alm_m_q, MIN_MAX);
      if (btn_snz) alm_en_d = !alm_en_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_RUN;
      time_set_q <= 1'b0;
      buzzer_q   <= 1'b0;
      snoozing_q <= 1'b0;
      inc_hr_q   <= 1'b0;
      inc_min_q  <= 1'b0;
      alm_h_q    <= 6'(ALM_H_RST);
      alm_m_q    <= 6'(ALM_M_RST);
      alm_en_q   <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      time_set_q <= time_set_d;
      buzzer_q   <= buzzer_d;
      snoozing_q <= snoozing_d;
      inc_hr_q   <= inc_hr_d;
      inc_min_q  <= inc_min_d;
      alm_h_q    <= alm_h_d;
      alm_m_q    <= alm_m_d;
      alm_en_q   <= alm_en_d;
    end
  end

  assign mode     = mode_q;
  assign time_set = time_set_q;
  assign inc_hr   = inc_hr_q;
  assign inc_min  = inc_min_q;
  assign alm_h    = alm_h_q;
  assign alm_m    = alm_m_q;
  assign alm_en   = alm_en_q;
  assign buzzer   = buzzer_q;
  assign snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
module tb_alarm_mode_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0, btn_hr = 1'b0, btn_min = 1'b0, btn_snz = 1'b0;
  logic [5:0] cur_h = 6'd0, cur_m = 6'd0, cur_s = 6'd0;
  logic [1:0] mode;
  logic       time_set, inc_hr, inc_min, alm_en, buzzer, snoozing;
  logic [5:0] alm_h, alm_m;

  alarm_mode_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_hr(btn_hr), .btn_min(btn_min), .btn_snz(btn_snz),
    .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
    .mode(mode), .time_set(time_set), .inc_hr(inc_hr), .inc_min(inc_min),
    .alm_h(alm_h), .alm_m(alm_m), .alm_en(alm_en),
    .buzzer(buzzer), .snoozing(snoozing)
  );

  int n_cmp = 0;
  int n_err = 0;
  int hr_incs = 0;
  int min_incs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_RUN = 0, P_SETT = 1, P_SETA = 2, P_RING = 3, P_SNZ = 4;
  int m_phase = P_RUN;
  int m_ah = 7, m_am = 0, m_left = 0;
  bit m_en = 1'b0, m_ihr = 1'b0, m_imin = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_RUN; m_ah = 7; m_am = 0; m_left = 0;
      m_en = 1'b0; m_ihr = 1'b0; m_imin = 1'b0;
    end else begin
      int ph;
      ph = m_phase;
      // at most one outstanding request per direction, consumed by a tick
      if (m_ihr)  m_ihr  = !tick_1hz; else m_ihr  = (ph == P_SETT) && btn_hr;
      if (m_imin) m_imin = !tick_1hz; else m_imin = (ph == P_SETT) && btn_min;
      case (ph)
        P_RUN:
          if (btn_mode) m_phase = P_SETT;
          else if (tick_1hz && m_en && cur_h == m_ah && cur_m == m_am && cur_s == 0) begin
            m_phase = P_RING; m_left = 60;
          end
        P_SETT: if (btn_mode) m_phase = P_SETA;
        P_SETA: begin
          if (btn_hr)  m_ah = (m_ah + 1) % 24;
          if (btn_min) m_am = (m_am + 1) % 60;
          if (btn_snz) m_en = !m_en;
          if (btn_mode) m_phase = P_RUN;
        end
        P_RING:
          if (btn_mode) m_phase = P_RUN;
          else if (btn_snz) begin m_phase = P_SNZ; m_left = 300; end
          else if (tick_1hz) begin
            m_left = m_left - 1;
            if (m_left <= 0) begin m_phase = P_RUN; m_left = 0; end
          end
        P_SNZ:
          if (btn_mode) m_phase = P_RUN;
          else if (tick_1hz) begin
            m_left = m_left - 1;
            if (m_left <= 0) begin m_phase = P_RING; m_left = 60; end
          end
        default: m_phase = P_RUN;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [1:0] e_mode;
    case (m_phase)
      P_SETT:  e_mode = 2'b01;
      P_SETA:  e_mode = 2'b10;
      P_RING:  e_mode = 2'b11;
      default: e_mode = 2'b00;
    endcase
    chk("mode",     {30'd0, mode},    {30'd0, e_mode});
    chk("time_set", {31'd0, time_set}, {31'd0, m_phase == P_SETT});
    chk("buzzer",   {31'd0, buzzer},   {31'd0, m_phase == P_RING});
    chk("snoozing", {31'd0, snoozing}, {31'd0, m_phase == P_SNZ});
    chk("inc_hr",   {31'd0, inc_hr},   {31'd0, m_ihr});
    chk("inc_min",  {31'd0, inc_min},  {31'd0, m_imin});
    chk("alm_h",    {26'd0, alm_h},    m_ah);
    chk("alm_m",    {26'd0, alm_m},    m_am);
    chk("alm_en",   {31'd0, alm_en},   {31'd0, m_en});
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int which);
    @(negedge clk);
    case (which)
      0: btn_mode = 1'b1;
      1: btn_hr   = 1'b1;
      2: btn_min  = 1'b1;
      default: btn_snz = 1'b1;
    endcase
    @(negedge clk);
    btn_mode = 1'b0; btn_hr = 1'b0; btn_min = 1'b0; btn_snz = 1'b0;
  endtask

  // One second strobe; also counts the increments the time counter would take.
  task automatic pulse_tick();
    @(negedge clk);
    tick_1hz = 1'b1;
    #1;
    if (inc_hr)  hr_incs++;
    if (inc_min) min_incs++;
    @(negedge clk);
    tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) pulse_tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, summary forced");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    idle(3);
    #2 rst_n = 1'b1;
    idle(1);
    chk("rst_mode", {30'd0, mode}, 0);
    chk("rst_alm_h", {26'd0, alm_h}, 7);
    chk("rst_alm_m", {26'd0, alm_m}, 0);
    chk("rst_alm_en", {31'd0, alm_en}, 0);

    // mode cycling
    press(0); chk("cyc_mode1", {30'd0, mode}, 1); chk("cyc_ts1", {31'd0, time_set}, 1);
    press(0); chk("cyc_mode2", {30'd0, mode}, 2); chk("cyc_ts2", {31'd0, time_set}, 0);
    press(0); chk("cyc_mode0", {30'd0, mode}, 0);

    // set time: double press before a tick gives one increment
    press(0);
    press(1); chk("inc_hr_set", {31'd0, inc_hr}, 1);
    idle(2);
    press(1); chk("inc_hr_held", {31'd0, inc_hr}, 1); chk("inc_min_quiet", {31'd0, inc_min}, 0);
    pulse_tick(); chk("inc_hr_clr", {31'd0, inc_hr}, 0);
    pulse_tick(); chk("hr_incs", hr_incs, 1); chk("min_incs0", min_incs, 0);
    // pending minute request survives leaving SET_TIME
    press(2);
    press(0); chk("seta_ts", {31'd0, time_set}, 0); chk("inc_min_pend", {31'd0, inc_min}, 1);
    pulse_tick(); chk("min_incs1", min_incs, 1); chk("inc_min_clr", {31'd0, inc_min}, 0);

    // set alarm: wrap both fields together
    repeat (16) press(1);
    repeat (59) press(2);
    chk("alm_h23", {26'd0, alm_h}, 23); chk("alm_m59", {26'd0, alm_m}, 59);
    @(negedge clk); btn_hr = 1'b1; btn_min = 1'b1;
    @(negedge clk); btn_hr = 1'b0; btn_min = 1'b0;
    chk("alm_h_wrap", {26'd0, alm_h}, 0); chk("alm_m_wrap", {26'd0, alm_m}, 0);
    repeat (7) press(1);
    press(3); chk("alm_en_on", {31'd0, alm_en}, 1);
    press(0); chk("back_run", {30'd0, mode}, 0);

    // alarm 07:00 rings and auto-dismisses after 60 ticks
    cur_h = 6'd7; cur_m = 6'd0; cur_s = 6'd0;
    pulse_tick(); chk("ring_buz", {31'd0, buzzer}, 1); chk("ring_mode", {30'd0, mode}, 3);
    cur_s = 6'd1;
    ticks(59); chk("ring_59", {31'd0, buzzer}, 1);
    pulse_tick(); chk("auto_off_buz", {31'd0, buzzer}, 0); chk("auto_off_mode", {30'd0, mode}, 0);
    chk("alm_en_kept", {31'd0, alm_en}, 1);

    // snooze 300 ticks then ring again
    cur_s = 6'd0; pulse_tick(); cur_s = 6'd1;
    press(3);
    chk("snz_flag", {31'd0, snoozing}, 1); chk("snz_buz", {31'd0, buzzer}, 0); chk("snz_mode", {30'd0, mode}, 0);
    ticks(299); chk("snz_299", {31'd0, snoozing}, 1);
    pulse_tick(); chk("resume_buz", {31'd0, buzzer}, 1); chk("resume_snz", {31'd0, snoozing}, 0);
    press(0); chk("dismiss", {30'd0, mode}, 0);

    // dismiss beats snooze in the same cycle
    cur_s = 6'd0; pulse_tick(); cur_s = 6'd1;
    @(negedge clk); btn_mode = 1'b1; btn_snz = 1'b1;
    @(negedge clk); btn_mode = 1'b0; btn_snz = 1'b0;
    chk("both_mode", {30'd0, mode}, 0); chk("both_snz", {31'd0, snoozing}, 0); chk("both_buz", {31'd0, buzzer}, 0);

    // btn_mode on the match tick wins and the match is lost
    cur_s = 6'd0;
    @(negedge clk); btn_mode = 1'b1; tick_1hz = 1'b1;
    @(negedge clk); btn_mode = 1'b0; tick_1hz = 1'b0;
    chk("lost_mode", {30'd0, mode}, 1); chk("lost_buz", {31'd0, buzzer}, 0);
    press(0); press(0);

    // reset during snooze
    pulse_tick(); cur_s = 6'd1;
    press(3); ticks(3);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_snz", {31'd0, snoozing}, 0); chk("arst_buz", {31'd0, buzzer}, 0);
    chk("arst_mode", {30'd0, mode}, 0); chk("arst_en", {31'd0, alm_en}, 0);
    chk("arst_alm_h", {26'd0, alm_h}, 7);
    idle(2);
    #2 rst_n = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
